// File: rtl/noc_demux_ctrl.sv
// Packet sequencer for the 1-to-4 NoC demux: decodes head flits,
// holds the select for the packet and issues flits against per-output credit.
module noc_demux_ctrl #(
  parameter int DATA_W  = 16,
  parameter int CREDITS = 4,
  parameter int CNT_W   = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] flit_i,
  input  logic              flit_valid_i,
  output logic              flit_ready_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        sel_o,
  output logic              enable_o,
  output logic [3:0]        valid_o,
  input  logic [3:0]        credit_return_i,
  output logic              pkt_done_o,
  output logic              busy_o,
  output logic              err_o
);

  typedef enum logic {
    IDLE,
    BODY
  } state_t;

  localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(CREDITS);

  state_t state_q, state_d;

  logic [1:0] cur_dest_q, cur_dest_d;
  logic [3:0] remain_q, remain_d;

  logic [3:0][CNT_W-1:0] credit_q, credit_d;

  logic       err_d;
  logic [1:0] hd_dest;
  logic [3:0] hd_len;
  logic [1:0] dest;
  logic       accept;
  logic       last;
  logic [3:0] take;

  assign hd_dest = flit_i[DATA_W-1 -: 2];
  assign hd_len  = flit_i[DATA_W-3 -: 4];
  assign busy_o  = (state_q == BODY);

  // Body flits carry no routing, so they follow the latched destination.
  always_comb begin
    dest = (state_q == IDLE) ? hd_dest : cur_dest_q;
    flit_ready_o = !rst_i && (credit_q[dest] != '0);
    accept = flit_valid_i && flit_ready_o;
    take = accept ? (4'b0001 << dest) : 4'b0000;
  end

  always_comb begin
    state_d    = state_q;
    cur_dest_d = cur_dest_q;
    remain_d   = remain_q;
    last       = 1'b0;
    if (accept) begin
      unique case (state_q)
        IDLE: begin
          if (hd_len == 4'd0) begin
            last = 1'b1;
          end else begin
            cur_dest_d = hd_dest;
            remain_d   = hd_len;
            state_d    = BODY;
          end
        end
        BODY: begin
          remain_d = remain_q - 4'd1;
          if (remain_q == 4'd1) begin
            last    = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A return in the same cycle as a take cancels out.
  always_comb begin
    credit_d = credit_q;
    err_d    = err_o;
    for (int k = 0; k < 4; k++) begin
      if (credit_return_i[k] && !take[k]) begin
        if (credit_q[k] == CRED_MAX) begin
          err_d = 1'b1;
        end else begin
          credit_d[k] = credit_q[k] + CNT_W'(1);
        end
      end else if (take[k] && !credit_return_i[k]) begin
        credit_d[k] = credit_q[k] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cur_dest_q <= 2'd0;
      remain_q   <= 4'd0;
      credit_q   <= {4{CRED_MAX}};
      err_o      <= 1'b0;
      data_o     <= '0;
      sel_o      <= 2'd0;
      enable_o   <= 1'b0;
      valid_o    <= 4'b0000;
      pkt_done_o <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_dest_q <= cur_dest_d;
      remain_q   <= remain_d;
      credit_q   <= credit_d;
      err_o      <= err_d;
      enable_o   <= accept;
      valid_o    <= take;
      pkt_done_o <= last;
      if (accept) begin
        data_o <= flit_i;
        sel_o  <= dest;
      end
    end
  end

endmodule

// File: tb/tb_noc_demux_ctrl.sv
// Directed and random checks of noc_demux_ctrl against a packet-level
// reference model held in the bench.
module tb_noc_demux_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [15:0] flit_i = '0;
  logic        flit_valid_i = 1'b0;
  logic        flit_ready_o;
  logic [15:0] data_o;
  logic [1:0]  sel_o;
  logic        enable_o;
  logic [3:0]  valid_o;
  logic [3:0]  credit_return_i = '0;
  logic        pkt_done_o;
  logic        busy_o;
  logic        err_o;

  noc_demux_ctrl #(.DATA_W(16), .CREDITS(4), .CNT_W(3)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .flit_i(flit_i),
    .flit_valid_i(flit_valid_i),
    .flit_ready_o(flit_ready_o),
    .data_o(data_o),
    .sel_o(sel_o),
    .enable_o(enable_o),
    .valid_o(valid_o),
    .credit_return_i(credit_return_i),
    .pkt_done_o(pkt_done_o),
    .busy_o(busy_o),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model: body flits still owed, packet destination, credits.
  int        m_cred [4];
  int        m_rem;
  int        m_dest;
  bit        m_err;
  bit        e_en, e_done;
  bit [3:0]  e_valid;
  bit [15:0] e_data;
  bit [1:0]  e_sel;
  int        issued;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready(input bit rst, input bit [15:0] f);
    int d;
    d = (m_rem > 0) ? m_dest : int'(f[15:14]);
    return !rst && (m_cred[d] > 0);
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 4; k++) m_cred[k] = 4;
    m_rem = 0; m_dest = 0; m_err = 0;
    e_en = 0; e_done = 0; e_valid = 0; e_data = 0; e_sel = 0;
  endtask

  task automatic cyc(input bit [15:0] f, input bit v,
                     input bit [3:0] ret, input bit rst);
    bit acc, rdy;
    int d, len;
    flit_i = f; flit_valid_i = v; credit_return_i = ret; rst_i = rst;
    #1;
    rdy = m_ready(rst, f);
    chk("ready", flit_ready_o, rdy);
    acc = v && rdy;
    d = (m_rem > 0) ? m_dest : int'(f[15:14]);
    if (rst) begin
      m_reset();
    end else begin
      e_done = 0;
      e_en = acc;
      e_valid = acc ? 4'(1 << d) : 4'b0;
      if (acc) begin
        e_data = f; e_sel = 2'(d);
        if (m_rem == 0) begin
          len = int'(f[13:10]);
          if (len == 0) e_done = 1;
          else begin m_rem = len; m_dest = d; end
        end else begin
          m_rem--;
          e_done = (m_rem == 0);
        end
      end
      for (int k = 0; k < 4; k++) begin
        if (ret[k] && !(acc && d == k)) begin
          if (m_cred[k] == 4) m_err = 1;
          else m_cred[k]++;
        end else if (!ret[k] && acc && d == k) begin
          m_cred[k]--;
        end
      end
    end
    @(posedge clk_i);
    #1;
    chk("enable", enable_o, e_en);
    chk("valid", valid_o, e_valid);
    chk("data", data_o, e_data);
    chk("sel", sel_o, e_sel);
    chk("done", pkt_done_o, e_done);
    chk("busy", busy_o, m_rem > 0);
    chk("err", err_o, m_err);
    for (int k = 0; k < 4; k++)
      chk("credit", 32'(dut.credit_q[k]), m_cred[k]);
    if (enable_o) issued++;
  endtask

  task automatic do_reset();
    cyc(16'h0, 0, 4'b0, 1);
    cyc(16'h0, 0, 4'b0, 1);
  endtask

  bit [1:0] sels [4];

  initial begin
    m_reset();
    issued = 0;
    do_reset();
    chk("rst_enable", enable_o, 1'b0);
    chk("rst_data", data_o, 16'h0);
    cyc(16'h0, 0, 4'b0, 0);

    // 1: single-flit packet
    cyc(16'h8000, 1, 4'b0, 0);
    chk("t1_valid", valid_o, 4'b0100);
    chk("t1_sel", sel_o, 2'd2);
    chk("t1_done", pkt_done_o, 1'b1);
    chk("t1_cred", 32'(dut.credit_q[2]), 3);

    // 2: head + 3 body to output 1
    do_reset();
    cyc(16'h4C00, 1, 4'b0, 0);
    chk("t2_busy0", busy_o, 1'b1);
    cyc(16'h1111, 1, 4'b0, 0);
    cyc(16'h2222, 1, 4'b0, 0);
    chk("t2_nodone", pkt_done_o, 1'b0);
    cyc(16'h3333, 1, 4'b0, 0);
    chk("t2_done", pkt_done_o, 1'b1);
    chk("t2_cred", 32'(dut.credit_q[1]), 0);

    // 3: credit stall on output 3
    do_reset();
    issued = 0;
    cyc(16'hDC00, 1, 4'b0, 0);
    for (int i = 0; i < 5; i++) cyc(16'hA5A5, 1, 4'b0, 0);
    chk("t3_stall", issued, 4);
    cyc(16'hA5A5, 1, 4'b1000, 0);
    for (int i = 0; i < 3; i++) cyc(16'hA5A5, 1, 4'b0, 0);
    chk("t3_one_more", issued, 5);

    // 4: cancelling return, then overflow return
    do_reset();
    cyc(16'h0001, 1, 4'b0, 0);
    cyc(16'h0002, 1, 4'b0001, 0);
    chk("t4_cancel", 32'(dut.credit_q[0]), 3);
    cyc(16'h0, 0, 4'b0100, 0);
    chk("t4_err", err_o, 1'b1);
    cyc(16'h0, 0, 4'b0, 0);
    cyc(16'h0, 0, 4'b0, 0);
    chk("t4_sticky", err_o, 1'b1);
    chk("t4_cnt", 32'(dut.credit_q[2]), 4);

    // 5: reset mid-packet
    do_reset();
    cyc(16'h5800, 1, 4'b0, 0);
    cyc(16'h0101, 1, 4'b0, 0);
    cyc(16'h0202, 1, 4'b0, 0);
    cyc(16'h0303, 1, 4'b0, 1);
    chk("t5_done", pkt_done_o, 1'b0);
    chk("t5_busy", busy_o, 1'b0);
    chk("t5_cred", 32'(dut.credit_q[1]), 4);
    cyc(16'h0, 0, 4'b0, 0);

    // 6: back-to-back packets
    do_reset();
    cyc(16'h0400, 1, 4'b0, 0); sels[0] = sel_o;
    chk("t6_en0", enable_o, 1'b1);
    cyc(16'h0BEE, 1, 4'b0, 0); sels[1] = sel_o;
    chk("t6_en1", enable_o, 1'b1);
    cyc(16'hC400, 1, 4'b0, 0); sels[2] = sel_o;
    chk("t6_en2", enable_o, 1'b1);
    cyc(16'h0CAF, 1, 4'b0, 0); sels[3] = sel_o;
    chk("t6_en3", enable_o, 1'b1);
    chk("t6_sels", {sels[0], sels[1], sels[2], sels[3]}, 8'b00_00_11_11);

    // Random traffic with legal credit returns.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bit [3:0] r;
      r = '0;
      for (int k = 0; k < 4; k++)
        if (m_cred[k] < 4 && $urandom_range(2) == 0) r[k] = 1'b1;
      cyc(16'($urandom), $urandom_range(3) != 0, r,
          $urandom_range(99) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
